// File: rtl/note_sequencer_if.sv
//------------------------------------------------------------------------------
// note_sequencer_if : control, melody-ROM and generator-side signals of note_sequencer
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface note_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic              stop;
    logic              loop;
    logic [ADDR_W-1:0] rom_addr;
    logic [11:0]       rom_data;
    logic [15:0]       freq;
    logic              note_active;
    logic              busy;
    logic              done;

    modport slave (
        input  start, stop, loop, rom_data,
        output rom_addr, freq, note_active, busy, done
    );

    modport master (
        output start, stop, loop, rom_data,
        input  rom_addr, freq, note_active, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/note_sequencer.sv
//------------------------------------------------------------------------------
// note_sequencer : walks a melody ROM, maps 6-bit note codes to Hz for the
//                  square-wave generator. Optional inter-note silence: NOTE_SEQUENCER_GAP_EN
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module note_sequencer #(
    parameter int TICK_CYCLES = 750000,
    parameter int ADDR_W      = 8,
    parameter int GAP_CYCLES  = 120000
) (
    input  wire logic          clk,
    input  wire logic          rst,
    note_sequencer_if.slave    bus
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_PLAY   = 3'd3,
        ST_GAP    = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    localparam logic [19:0] C_TICK_LAST = 20'(TICK_CYCLES - 1);
    localparam logic [5:0]  C_END_CODE  = 6'd63;

    state_t            r_state, w_state;
    logic [ADDR_W-1:0] r_addr, w_addr;
    logic [15:0]       r_freq, w_freq;
    logic              r_note_active, w_note_active;
    logic [19:0]       r_tick, w_tick;
    logic [5:0]        r_dur_cnt, w_dur_cnt;
    logic [5:0]        r_dur, w_dur;
    logic [5:0]        w_code;
    logic [5:0]        w_rom_dur;

    // 12-TET, A4 = 440 Hz, code 1 = C4, rounded to the nearest Hz
    function automatic logic [15:0] note_hz(input logic [5:0] code);
        case (code)
            6'd1:  note_hz = 16'd262;  6'd2:  note_hz = 16'd277;  6'd3:  note_hz = 16'd294;
            6'd4:  note_hz = 16'd311;  6'd5:  note_hz = 16'd330;  6'd6:  note_hz = 16'd349;
            6'd7:  note_hz = 16'd370;  6'd8:  note_hz = 16'd392;  6'd9:  note_hz = 16'd415;
            6'd10: note_hz = 16'd440;  6'd11: note_hz = 16'd466;  6'd12: note_hz = 16'd494;
            6'd13: note_hz = 16'd523;  6'd14: note_hz = 16'd554;  6'd15: note_hz = 16'd587;
            6'd16: note_hz = 16'd622;  6'd17: note_hz = 16'd659;  6'd18: note_hz = 16'd698;
            6'd19: note_hz = 16'd740;  6'd20: note_hz = 16'd784;  6'd21: note_hz = 16'd831;
            6'd22: note_hz = 16'd880;  6'd23: note_hz = 16'd932;  6'd24: note_hz = 16'd988;
            6'd25: note_hz = 16'd1047; 6'd26: note_hz = 16'd1109; 6'd27: note_hz = 16'd1175;
            6'd28: note_hz = 16'd1245; 6'd29: note_hz = 16'd1319; 6'd30: note_hz = 16'd1397;
            6'd31: note_hz = 16'd1480; 6'd32: note_hz = 16'd1568; 6'd33: note_hz = 16'd1661;
            6'd34: note_hz = 16'd1760; 6'd35: note_hz = 16'd1865; 6'd36: note_hz = 16'd1976;
            6'd37: note_hz = 16'd2093; 6'd38: note_hz = 16'd2217; 6'd39: note_hz = 16'd2349;
            6'd40: note_hz = 16'd2489; 6'd41: note_hz = 16'd2637; 6'd42: note_hz = 16'd2794;
            6'd43: note_hz = 16'd2960; 6'd44: note_hz = 16'd3136; 6'd45: note_hz = 16'd3322;
            6'd46: note_hz = 16'd3520; 6'd47: note_hz = 16'd3729; 6'd48: note_hz = 16'd3951;
            default: note_hz = 16'd0;
        endcase
    endfunction

    assign w_code    = bus.rom_data[11:6];
    assign w_rom_dur = bus.rom_data[5:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_addr        <= '0;
            r_freq        <= '0;
            r_note_active <= 1'b0;
            r_tick        <= '0;
            r_dur_cnt     <= '0;
            r_dur         <= '0;
        end else begin
            r_state       <= w_state;
            r_addr        <= w_addr;
            r_freq        <= w_freq;
            r_note_active <= w_note_active;
            r_tick        <= w_tick;
            r_dur_cnt     <= w_dur_cnt;
            r_dur         <= w_dur;
        end
    end

    always_comb begin
        w_state       = r_state;
        w_addr        = r_addr;
        w_freq        = r_freq;
        w_note_active = r_note_active;
        w_tick        = r_tick;
        w_dur_cnt     = r_dur_cnt;
        w_dur         = r_dur;

        case (r_state)
            ST_IDLE: begin
                w_freq        = '0;
                w_note_active = 1'b0;
                if (bus.start) begin
                    w_addr  = '0;
                    w_state = ST_FETCH;
                end
            end
            ST_FETCH: w_state = ST_DECODE;
            ST_DECODE: begin
                if (w_code == C_END_CODE) begin
                    if (bus.loop) begin
                        w_addr  = '0;
                        w_state = ST_FETCH;
                    end else begin
                        w_freq        = '0;
                        w_note_active = 1'b0;
                        w_state       = ST_DONE;
                    end
                end else begin
                    if (w_code >= 6'd1 && w_code <= 6'd48) begin
                        w_freq        = note_hz(w_code);
                        w_note_active = 1'b1;
                    end else begin
                        w_freq        = '0;
                        w_note_active = 1'b0;
                    end
                    w_dur     = (w_rom_dur == 6'd0) ? 6'd1 : w_rom_dur;
                    w_tick    = '0;
                    w_dur_cnt = '0;
                    w_state   = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (r_tick == C_TICK_LAST) begin
                    w_tick = '0;
                    if (r_dur_cnt == r_dur - 6'd1) begin
                        w_addr = r_addr + 1'b1;
`ifdef NOTE_SEQUENCER_GAP_EN
                        w_freq        = '0;
                        w_note_active = 1'b0;
                        w_state       = ST_GAP;
`else
                        w_state = ST_FETCH;
`endif
                    end else begin
                        w_dur_cnt = r_dur_cnt + 6'd1;
                    end
                end else begin
                    w_tick = r_tick + 20'd1;
                end
            end
`ifdef NOTE_SEQUENCER_GAP_EN
            ST_GAP: begin
                if (r_tick == 20'(GAP_CYCLES - 1)) begin
                    w_tick  = '0;
                    w_state = ST_FETCH;
                end else begin
                    w_tick = r_tick + 20'd1;
                end
            end
`endif
            ST_DONE: w_state = ST_IDLE;
            default: w_state = ST_IDLE;
        endcase

        // stop overrides everything, including a start in the same cycle; the address is frozen
        if (bus.stop) begin
            w_state       = ST_IDLE;
            w_addr        = r_addr;
            w_freq        = '0;
            w_note_active = 1'b0;
        end
    end

    assign bus.rom_addr    = r_addr;
    assign bus.freq        = r_freq;
    assign bus.note_active = r_note_active;
    assign bus.busy        = (r_state != ST_IDLE);
    assign bus.done        = (r_state == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_note_sequencer.sv
//------------------------------------------------------------------------------
// tb_note_sequencer : bench for note_sequencer; expected output timelines are
//                     expanded from the melody ROM contents
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_note_sequencer;

    localparam int T     = 4;
    localparam int G_CYC = 3;
    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;
`ifdef NOTE_SEQUENCER_GAP_EN
    localparam int GAPN = G_CYC;
`else
    localparam int GAPN = 0;
`endif

    typedef struct {
        logic [15:0]   f;
        logic          na;
        logic          busy;
        logic          done;
        logic [AW-1:0] a;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic [11:0] rom [DEPTH];
    exp_t exp_q[$];
    exp_t tl[$];
    int vectors  = 0;
    int errors   = 0;
    int done_cnt = 0;
    int last_addr = 0;

    note_sequencer_if #(.ADDR_W(AW)) bus ();

    note_sequencer #(
        .TICK_CYCLES(T),
        .ADDR_W     (AW),
        .GAP_CYCLES (G_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];
    always @(posedge clk) if (bus.done === 1'b1) done_cnt++;

    // Equal-tempered pitch straight from the A4 = 440 Hz definition
    function automatic int note_hz(input int code);
        real r;
        r = 440.0 * (2.0 ** ((code - 10) / 12.0));
        return $rtoi(r + 0.5);
    endfunction

    function automatic logic [11:0] ent(input int code, input int dur);
        logic [5:0] c6, d6;
        c6 = code[5:0];
        d6 = dur[5:0];
        return {c6, d6};
    endfunction

    task automatic set_rom(input logic [11:0] w0, w1, w2, w3);
        rom[0] = w0; rom[1] = w1; rom[2] = w2; rom[3] = w3;
    endtask

    function automatic void pushe(input int f, input bit na, input bit b, input bit d, input int a);
        exp_t e;
        e.f = f[15:0]; e.na = na; e.busy = b; e.done = d; e.a = a[AW-1:0];
        tl.push_back(e);
    endfunction

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Per-cycle expected outputs of a playback started from address 0
    task automatic build(input bit lp, input int maxc);
        int a, code, dur, f;
        bit na;
        a = 0; f = 0; na = 0;
        tl.delete();
        while (tl.size() < maxc) begin
            code = int'(rom[a][11:6]);
            dur  = int'(rom[a][5:0]);
            if (dur == 0) dur = 1;
            pushe(f, na, 1, 0, a);
            pushe(f, na, 1, 0, a);
            if (code == 63) begin
                if (lp) begin
                    a = 0;
                    continue;
                end
                pushe(0, 0, 1, 1, a);
                pushe(0, 0, 0, 0, a);
                break;
            end
            if (code >= 1 && code <= 48) begin f = note_hz(code); na = 1; end
            else begin f = 0; na = 0; end
            repeat (dur * T) pushe(f, na, 1, 0, a);
            a = (a + 1) % DEPTH;
            if (GAPN > 0) begin
                f = 0; na = 0;
                repeat (GAPN) pushe(0, 0, 1, 0, a);
            end
        end
        if (tl.size() > maxc) tl = tl[0:maxc-1];
    endtask

    // One playback: pulse start, optionally stop after stop_k cycles, optionally
    // re-pulse start while busy (must be ignored)
    task automatic run(input bit lp, input int maxc, input int stop_k, input int xs_in);
        int stop_at, xs, n, la;
        build(lp, maxc);
        stop_at = 0;
        if (stop_k > 0 && stop_k < tl.size()) tl = tl[0:stop_k-1];
        if (tl[tl.size()-1].busy) begin
            stop_at = tl.size();
            la = int'(tl[tl.size()-1].a);
            repeat (3) pushe(0, 0, 0, 0, la);
        end
        xs = 0;
        if (xs_in >= 2 && xs_in < tl.size() && xs_in != stop_at)
            if (tl[xs_in-1].busy) xs = xs_in;
        @(negedge clk); #1;
        bus.start = 1'b1;
        foreach (tl[i]) exp_q.push_back(tl[i]);
        n = tl.size();
        for (int c = 1; c <= n; c++) begin
            @(negedge clk); #1;
            bus.start = (c == xs);
            bus.stop  = (c == stop_at);
        end
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        last_addr = int'(tl[tl.size()-1].a);
    endtask

    always @(negedge clk) begin : compare
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (bus.freq !== e.f || bus.note_active !== e.na || bus.busy !== e.busy ||
                bus.done !== e.done || bus.rom_addr !== e.a) begin
                errors++;
                $display("FAIL cycle@%0t: freq %0d/%0d note_active %b/%b busy %b/%b done %b/%b rom_addr %0d/%0d (got/expected)",
                         $time, bus.freq, e.f, bus.note_active, e.na, bus.busy, e.busy,
                         bus.done, e.done, bus.rom_addr, e.a);
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int code;
        rst = 1'b1;
        bus.start = 1'b0; bus.stop = 1'b0; bus.loop = 1'b0;
        set_rom(12'd0, 12'd0, 12'd0, 12'd0);
        repeat (2) @(negedge clk);
        check("reset_freq", int'(bus.freq), 0);
        check("reset_note_active", int'(bus.note_active), 0);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_done", int'(bus.done), 0);
        check("reset_rom_addr", int'(bus.rom_addr), 0);
        #1 rst = 1'b0;

        check("model_hz_c4", note_hz(1), 262);
        check("model_hz_a4", note_hz(10), 440);
        check("model_hz_c5", note_hz(13), 523);
        check("model_hz_a5", note_hz(22), 880);
        check("model_hz_b7", note_hz(48), 3951);

        // 1: single note then end marker
        set_rom(ent(10, 2), ent(63, 0), 12'd0, 12'd0);
        bus.loop = 1'b0; done_cnt = 0;
        run(0, 100, 0, 0);
        check("t1_model_first_440", int'(tl[2].f), 440);
        check("t1_model_last_440", int'(tl[9].f), 440);
        check("t1_done_pulses", done_cnt, 1);

        // 2: rest then zero-duration note
        set_rom(ent(0, 3), ent(22, 0), ent(63, 0), 12'd0);
        run(0, 100, 0, 0);

        // 3: looping melody, halted by stop
        set_rom(ent(1, 1), ent(63, 0), 12'd0, 12'd0);
        bus.loop = 1'b1; done_cnt = 0;
        run(1, 60, 0, 0);
        check("t3_no_done", done_cnt, 0);
        bus.loop = 1'b0;

        // 4a: stop during PLAY
        set_rom(ent(10, 2), ent(63, 0), 12'd0, 12'd0);
        done_cnt = 0;
        run(0, 100, 6, 0);
        check("t4_stop_no_done", done_cnt, 0);

        // 4b: asynchronous reset during PLAY
        @(negedge clk); #1 bus.start = 1'b1;
        @(negedge clk); #1 bus.start = 1'b0;
        repeat (4) @(negedge clk);
        check("t4_freq_before_rst", int'(bus.freq), 440);
        #1 rst = 1'b1;
        #1;
        check("t4_rst_freq", int'(bus.freq), 0);
        check("t4_rst_note_active", int'(bus.note_active), 0);
        check("t4_rst_busy", int'(bus.busy), 0);
        check("t4_rst_rom_addr", int'(bus.rom_addr), 0);
        tl.delete();
        repeat (2) pushe(0, 0, 0, 0, 0);
        foreach (tl[i]) exp_q.push_back(tl[i]);
        @(negedge clk); #1 rst = 1'b0;
        @(negedge clk); #1;
        last_addr = 0;

        // 4c: start and stop together while idle
        tl.delete();
        repeat (3) pushe(0, 0, 0, 0, last_addr);
        bus.start = 1'b1; bus.stop = 1'b1;
        foreach (tl[i]) exp_q.push_back(tl[i]);
        @(negedge clk); #1 bus.start = 1'b0; bus.stop = 1'b0;
        repeat (2) @(negedge clk);
        #1;

        // 5: address wrap, no end marker
        set_rom(ent(13, 1), ent(13, 1), ent(13, 1), ent(13, 1));
        run(0, 40, 0, 0);

        // 6: repeated identical notes (silence between them when the gap is built in)
        set_rom(ent(10, 1), ent(10, 1), ent(63, 0), 12'd0);
        run(0, 100, 0, 0);

        // randomized melodies, loop setting, stop points and ignored restarts
        for (int r = 0; r < 30; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                code = ($urandom_range(0, 4) == 0) ? 63 : int'($urandom_range(0, 63));
                rom[i] = ent(code, int'($urandom_range(0, 3)));
            end
            bus.loop = 1'($urandom_range(0, 1));
            run(bus.loop, 90, ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 80)) : 0,
                int'($urandom_range(2, 60)));
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire
